// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory behind a valid/ready request
// port with a fixed response latency.
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_addr          byte address (must be word aligned and in range)
//   req_wdata         store data
//   resp_valid        one-cycle response strobe, LATENCY edges after accept
//   resp_rdata        load data (0 for stores and errors)
//   resp_err          misaligned or out-of-range address, no write performed
// A request accepted at edge N commits (memory access, response registered)
// at edge N+LATENCY; the responder is idle again after edge N+LATENCY+1.
module data_mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               commit_c;
  logic               addr_err_c;
  logic               mem_we_c;
  logic [ADDR_W-1:0]  idx_c;
  logic [31:0]        mem_q [DEPTH];

  // Address checks on the captured request: alignment and all bits above the
  // word index must be zero.
  assign idx_c      = addr_q[ADDR_W+1:2];
  assign addr_err_c = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0);

  // Write is suppressed when reset coincides with the commit edge.
  assign mem_we_c = commit_c && we_q && !addr_err_c && !rst;

  // State and captured request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and commit logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    commit_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Counter reaching zero means the coming edge is the commit edge.
        if (cnt_q == '0) begin
          commit_c = 1'b1;
          state_d  = S_RESP;
          err_d    = addr_err_c;
          rdata_d  = (addr_err_c || we_q) ? 32'd0 : mem_q[idx_c];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Backing storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[idx_c] <= wdata_q;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LAT    = 2;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Shared stimulus for the latency-boundary instances.
  logic        lv1 = 1'b0, lv15 = 1'b0;
  logic        lr1, lr15, lrv1, lrv15, le1, le15;
  logic [31:0] lrd1, lrd15;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          known   [DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(lv1), .req_ready(lr1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(lrv1), .resp_rdata(lrd1), .resp_err(le1)
  );

  data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(15)) u_lat15 (
    .clk(clk), .rst(rst), .req_valid(lv15), .req_ready(lr15),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(lrv15), .resp_rdata(lrd15), .resp_err(le15)
  );

  // Reference memory: applies one request to the model and returns the
  // response it must produce.
  function automatic void model(input bit we, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output bit er, output bit rd_known);
    int unsigned w;
    er       = (a % 4 != 0) || (a >= 4 * DEPTH);
    rd       = 32'd0;
    rd_known = 1'b1;
    if (!er) begin
      w = a / 4;
      if (we) begin
        ref_mem[w] = d;
        known[w]   = 1'b1;
      end else begin
        rd       = ref_mem[w];
        rd_known = known[w];
      end
    end
  endfunction

  // One full transaction against the main instance with timing checks.
  task automatic do_txn(input string nm, input bit we, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    bit          exp_er, exp_known, got, ready_bad;
    int          k;
    model(we, a, d, exp_rd, exp_er, exp_known);
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout: req_ready=%b required 1", nm, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 1'b0; ready_bad = 1'b0;
    for (k = 1; k <= int'(LAT) + 4; k++) begin
      if (req_ready !== 1'b0) ready_bad = 1'b1;
      @(posedge clk); #1;
      if (resp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || k != int'(LAT)) begin
      errors++;
      $display("FAIL %s latency: got=%0b edges=%0d required %0d", nm, got, k, LAT);
    end
    checks++;
    if (ready_bad || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_busy: req_ready high while busy, required 0", nm);
    end
    checks++;
    if (resp_err !== exp_er) begin
      errors++;
      $display("FAIL %s err: got %b required %b", nm, resp_err, exp_er);
    end
    if (exp_known) begin
      checks++;
      if (resp_rdata !== exp_rd) begin
        errors++;
        $display("FAIL %s rdata: got %h required %h", nm, resp_rdata, exp_rd);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_resp: valid=%b ready=%b required 0/1", nm, resp_valid, req_ready);
    end
    if (exp_known) begin
      checks++;
      if (resp_rdata !== exp_rd) begin
        errors++;
        $display("FAIL %s rdata_hold: got %h required %h", nm, resp_rdata, exp_rd);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_store_load();
    do_txn("store_10", 1'b1, 32'h10, 32'hDEADBEEF);
    do_txn("load_10", 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_errors();
    do_txn("store_0", 1'b1, 32'h0, 32'h5A5A0001);
    do_txn("load_misaligned", 1'b0, 32'h12, 32'h0);
    do_txn("load_oor", 1'b0, 32'h400, 32'h0);
    do_txn("store_misaligned", 1'b1, 32'h12, 32'h11111111);
    do_txn("store_oor", 1'b1, 32'h400, 32'h22222222);
    do_txn("store_highbits", 1'b1, 32'h8000_0010, 32'h33333333);
    do_txn("load_10_unchanged", 1'b0, 32'h10, 32'h0);
    do_txn("load_0_unchanged", 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 16; i++)
      do_txn("rnd_init", 1'b1, 32'h40 + 32'(4 * i), $urandom);
    for (int i = 0; i < 30; i++) begin
      a = ($urandom % 8 == 0) ? 32'($urandom) : 32'h40 + 32'(4 * ($urandom % 16));
      do_txn("rnd_op", 1'($urandom % 2), a, $urandom);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] exp_rd, a;
    bit          er, kn;
    int          acc_cyc[$];
    int          resps, got_rd;
    do_txn("b2b_init_14", 1'b1, 32'h14, 32'hCAFE0014);
    resps = 0; got_rd = 0;
    a = 32'h10;
    req_we = 1'b0; req_addr = a; req_valid = 1'b1;
    for (int c = 0; c < 4 * (int'(LAT) + 2) + int'(LAT) + 3; c++) begin
      if (c >= 4 * (int'(LAT) + 2)) req_valid = 1'b0;
      if (req_ready && req_valid) begin
        acc_cyc.push_back(c);
        model(1'b0, a, 32'h0, exp_rd, er, kn);
        exp_q.push_back(exp_rd);
      end
      @(posedge clk); #1;
      if (resp_valid === 1'b1) begin
        resps++;
        if (exp_q.size() > 0) begin
          exp_rd = exp_q.pop_front();
          checks++;
          if (resp_rdata !== exp_rd) begin
            errors++;
            $display("FAIL b2b_rdata: got %h required %h", resp_rdata, exp_rd);
          end
        end
      end
      if (req_ready) begin
        a = (a == 32'h10) ? 32'h14 : 32'h10;
        req_addr = a;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (acc_cyc.size() != 4 || resps != acc_cyc.size()) begin
      errors++;
      $display("FAIL b2b_count: accepts=%0d responses=%0d required 4/4", acc_cyc.size(), resps);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != int'(LAT) + 2) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d cycles required %0d", acc_cyc[i] - acc_cyc[i-1], LAT + 2);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    do_txn("abort_pre", 1'b1, 32'h20, 32'h0);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (int'(LAT) + 3) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_resp: resp_valid seen=1 required 0");
    end
    do_txn("abort_load_20", 1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_top_index();
    do_txn("top_store0", 1'b1, 32'h0, 32'h0BADF00D);
    do_txn("top_store", 1'b1, 32'h3FC, 32'hFFFFFFFF);
    do_txn("top_load", 1'b0, 32'h3FC, 32'h0);
    do_txn("top_load0", 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_latency_bounds();
    int  exp_lat, k;
    bit  got, ready_back;
    for (int i = 0; i < 2; i++) begin
      exp_lat = (i == 0) ? 1 : 15;
      req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h0000_00A5;
      if (i == 0) lv1 = 1'b1; else lv15 = 1'b1;
      @(posedge clk); #1;
      lv1 = 1'b0; lv15 = 1'b0;
      got = 1'b0;
      for (k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (((i == 0) ? lrv1 : lrv15) === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      checks++;
      if (!got || k != exp_lat || ((i == 0) ? le1 : le15) !== 1'b0) begin
        errors++;
        $display("FAIL latency_%0d: got=%0b edges=%0d required %0d with err=0", exp_lat, got, k, exp_lat);
      end
      @(posedge clk); #1;
      ready_back = (i == 0) ? lr1 : lr15;
      checks++;
      if (ready_back !== 1'b1 || ((i == 0) ? lrv1 : lrv15) !== 1'b0) begin
        errors++;
        $display("FAIL latency_%0d_ready: ready=%b required 1 one edge after response", exp_lat, ready_back);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_mem[i] = 'x;
      known[i]   = 1'b0;
    end
    test_reset();
    test_store_load();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_top_index();
    test_latency_bounds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
